// File: rtl/uart_mem_loader.sv
// uart_mem_loader: host-driven loader. It requests bytes one at a time over a UART
// byte interface, packs them little-endian into WORD_BYTES-wide words and writes
// LOAD_LEN words to consecutive addresses of a memory write port.
// Each request echoes the previously received byte, and the host treats that echo as an ACK.
// A byte that does not arrive within TIMEOUT_CYCLES is requested again with the same tx_data.
// MAX_RETRIES consecutive timeouts on one byte end the load in ERROR.
// Optional feature macro: UART_LOADER_CHECKSUM_EN. When it is defined, one extra check
// byte must follow the last word. That byte must equal the two's complement of the
// 8-bit sum of all data bytes.
// Handshake: rx_valid and tx_done are one-cycle pulses from the uart core.
// tx_wr and mem_we are one-cycle pulses. tx_data is stable while tx_wr is high.
// mem_addr and mem_di are stable while mem_we is high. There is no backpressure.
module uart_mem_loader #(
   parameter int ADDR_WIDTH     = 14,
   parameter int WORD_BYTES     = 1,
   parameter int LOAD_LEN       = 16384,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRIES    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   input  logic                    tx_done,
   output logic [7:0]              tx_data,
   output logic                    tx_wr,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [8*WORD_BYTES-1:0] mem_di,
   output logic                    mem_we,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [3:0]              state_dbg
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_REQUEST = 4'd1;
   localparam logic [3:0] S_WAIT_TX = 4'd2;
   localparam logic [3:0] S_RECV    = 4'd3;
   localparam logic [3:0] S_WRITE   = 4'd4;
   localparam logic [3:0] S_NEXT    = 4'd5;
   localparam logic [3:0] S_DONE    = 4'd6;
   localparam logic [3:0] S_ERROR   = 4'd7;
`ifdef UART_LOADER_CHECKSUM_EN
   localparam logic [3:0] S_CHECK   = 4'd8;
`endif

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RTY_W = $clog2(MAX_RETRIES + 1);
   localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int CNT_W = $clog2(LOAD_LEN + 1);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_LEN - 1);

   logic [3:0]       state;
   logic [TMR_W-1:0] timer;
   logic [RTY_W-1:0] retry;
   logic [IDX_W-1:0] byte_idx;
   logic [CNT_W-1:0] word_cnt;
   logic             pending;
   logic [7:0]       rx_byte;
   logic             consume;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]       sum;
   logic             chk_phase;
`endif

   // State-decoded strobes and status.
   assign tx_wr     = (state == S_REQUEST);
   assign mem_we    = (state == S_WRITE);
   assign done      = (state == S_DONE);
   assign error     = (state == S_ERROR);
   assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
   assign state_dbg = state;
   assign consume   = (state == S_RECV) && pending;

   // Catch a received byte. A reply that lands on a request cycle is stale and is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         rx_byte <= 8'h00;
      end else if (rx_valid && !tx_wr) begin
         pending <= 1'b1;
         rx_byte <= rx_data;
      end else if (tx_wr || consume) begin
         pending <= 1'b0;
      end
   end

   // Main load sequencer: request, wait for the send, receive with retry, pack, write, advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         tx_data  <= 8'h00;
         mem_addr <= '0;
         mem_di   <= '0;
         timer    <= '0;
         retry    <= '0;
         byte_idx <= '0;
         word_cnt <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
         sum       <= 8'h00;
         chk_phase <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state    <= S_REQUEST;
                  mem_addr <= '0;
                  word_cnt <= '0;
                  byte_idx <= '0;
                  tx_data  <= 8'h00;
                  retry    <= '0;
                  timer    <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                  sum       <= 8'h00;
                  chk_phase <= 1'b0;
`endif
               end
            end
            S_REQUEST: begin
               timer <= '0;
               state <= S_WAIT_TX;
            end
            S_WAIT_TX: begin
               if (tx_done) state <= S_RECV;
            end
            S_RECV: begin
               if (pending) begin
                  tx_data <= rx_byte;
                  retry   <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                  if (chk_phase) begin
                     state <= (rx_byte == (8'h00 - sum)) ? S_DONE : S_ERROR;
                  end else begin
                     sum <= sum + rx_byte;
`else
                  begin
`endif
                     for (int i = 0; i < WORD_BYTES; i++) begin
                        if (byte_idx == IDX_W'(i)) mem_di[8*i +: 8] <= rx_byte;
                     end
                     if (byte_idx == IDX_LAST) begin
                        state <= S_WRITE;
                     end else begin
                        byte_idx <= byte_idx + IDX_W'(1);
                        state    <= S_REQUEST;
                     end
                  end
               end else if (timer == TMR_LAST) begin
                  // A timed-out byte is re-requested with unchanged tx_data.
                  if (retry == RTY_LAST) begin
                     state <= S_ERROR;
                  end else begin
                     retry <= retry + RTY_W'(1);
                     state <= S_REQUEST;
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_WRITE: begin
               byte_idx <= '0;
               state    <= S_NEXT;
            end
            S_NEXT: begin
               if (word_cnt == CNT_LAST) begin
`ifdef UART_LOADER_CHECKSUM_EN
                  state <= S_CHECK;
`else
                  state <= S_DONE;
`endif
               end else begin
                  mem_addr <= mem_addr + ADDR_WIDTH'(1);
                  word_cnt <= word_cnt + CNT_W'(1);
                  state    <= S_REQUEST;
               end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            S_CHECK: begin
               chk_phase <= 1'b1;
               state     <= S_REQUEST;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader. Instance a uses byte-wide words and LOAD_LEN=4.
// Instance b uses 16-bit words and LOAD_LEN=2.
// Both instances use a 16-cycle timeout and 3 retries.
module tb_uart_mem_loader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic        start_a, rx_valid_a, tx_done_a;
   logic [7:0]  rx_data_a, tx_data_a;
   logic        tx_wr_a, mem_we_a, busy_a, done_a, error_a;
   logic [3:0]  mem_addr_a, state_a;
   logic [7:0]  mem_di_a;

   logic        start_b, rx_valid_b, tx_done_b;
   logic [7:0]  rx_data_b, tx_data_b;
   logic        tx_wr_b, mem_we_b, busy_b, done_b, error_b;
   logic [3:0]  mem_addr_b, state_b;
   logic [15:0] mem_di_b;

   logic [11:0] exp_wr_a[$];
   logic [7:0]  exp_tx_a[$];
   logic [19:0] exp_wr_b[$];

   logic [7:0]  last_tx_a, sum_a, sum_b;

   uart_mem_loader #(.ADDR_WIDTH(4), .WORD_BYTES(1), .LOAD_LEN(4),
                     .TIMEOUT_CYCLES(16), .MAX_RETRIES(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
      .tx_done(tx_done_a), .tx_data(tx_data_a), .tx_wr(tx_wr_a), .mem_addr(mem_addr_a),
      .mem_di(mem_di_a), .mem_we(mem_we_a), .busy(busy_a), .done(done_a), .error(error_a),
      .state_dbg(state_a));

   uart_mem_loader #(.ADDR_WIDTH(4), .WORD_BYTES(2), .LOAD_LEN(2),
                     .TIMEOUT_CYCLES(16), .MAX_RETRIES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
      .tx_done(tx_done_b), .tx_data(tx_data_b), .tx_wr(tx_wr_b), .mem_addr(mem_addr_b),
      .mem_di(mem_di_b), .mem_we(mem_we_b), .busy(busy_b), .done(done_b), .error(error_b),
      .state_dbg(state_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   // Scoreboard monitor: every write and request pops its expected entry.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we_a) begin
            if (exp_wr_a.size() == 0) flag("unexpected write a");
            else check("write a {addr,data}", 32'({mem_addr_a, mem_di_a}), 32'(exp_wr_a.pop_front()));
         end
         if (tx_wr_a) begin
            if (exp_tx_a.size() == 0) flag("unexpected request a");
            else check("tx_data a", 32'(tx_data_a), 32'(exp_tx_a.pop_front()));
         end
         if (mem_we_b) begin
            if (exp_wr_b.size() == 0) flag("unexpected write b");
            else check("write b {addr,data}", 32'({mem_addr_b, mem_di_b}), 32'(exp_wr_b.pop_front()));
         end
      end
   end

   task automatic wait_tx_a(output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < 300 && !ok) begin
         if (tx_wr_a) ok = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      if (!ok) flag("timeout waiting for tx_wr a");
   endtask

   // Serves one request: checks the echo, completes the send, and replies if asked.
   // With stale set, it also fires a reply in the same cycle as tx_wr.
   task automatic host_a(input logic [7:0] b, input bit reply, input bit stale);
      bit ok;
      exp_tx_a.push_back(last_tx_a);
      wait_tx_a(ok);
      if (ok) begin
         if (stale) begin
            rx_data_a  = 8'hEE;
            rx_valid_a = 1'b1;
         end
         @(negedge clk);
         rx_valid_a = 1'b0;
         @(negedge clk);
         tx_done_a = 1'b1;
         @(negedge clk);
         tx_done_a = 1'b0;
         if (reply) begin
            @(negedge clk);
            rx_data_a  = b;
            rx_valid_a = 1'b1;
            @(negedge clk);
            rx_valid_a = 1'b0;
            last_tx_a  = b;
            sum_a      = sum_a + b;
         end
      end
   endtask

   task automatic host_b(input logic [7:0] b);
      int n = 0;
      while (n < 300 && !tx_wr_b) begin
         @(negedge clk);
         n++;
      end
      if (!tx_wr_b) flag("timeout waiting for tx_wr b");
      else begin
         @(negedge clk);
         tx_done_b = 1'b1;
         @(negedge clk);
         tx_done_b = 1'b0;
         @(negedge clk);
         rx_data_b  = b;
         rx_valid_b = 1'b1;
         @(negedge clk);
         rx_valid_b = 1'b0;
         sum_b      = sum_b + b;
      end
   endtask

   task automatic start_a_load();
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a   = 1'b0;
      last_tx_a = 8'h00;
      sum_a     = 8'h00;
   endtask

   // In the checksum build, this sends the closing check byte. Otherwise it does nothing.
   task automatic check_byte_a();
`ifdef UART_LOADER_CHECKSUM_EN
      host_a(8'h00 - sum_a, 1'b1, 1'b0);
`endif
   endtask

   task automatic wait_idle_a();
      int n = 0;
      while (n < 300 && busy_a) begin
         @(negedge clk);
         n++;
      end
      if (busy_a) flag("timeout waiting for a to finish");
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0;
      start_a = 1'b0; rx_valid_a = 1'b0; tx_done_a = 1'b0; rx_data_a = 8'h00;
      start_b = 1'b0; rx_valid_b = 1'b0; tx_done_b = 1'b0; rx_data_b = 8'h00;
      last_tx_a = 8'h00; sum_a = 8'h00; sum_b = 8'h00;
      repeat (3) @(negedge clk);
      check("reset outputs a", 32'({tx_wr_a, mem_we_a, busy_a, done_a, error_a, tx_data_a, mem_addr_a, mem_di_a}), 32'd0);
      check("reset outputs b", 32'({tx_wr_b, mem_we_b, busy_b, done_b, error_b, tx_data_b, mem_addr_b, mem_di_b}), 32'd0);
      rst_n = 1'b1;

      // Basic byte load: replies 11,22,33,44, giving echoes 00,11,22,33.
      exp_wr_a.push_back({4'd0, 8'h11}); exp_wr_a.push_back({4'd1, 8'h22});
      exp_wr_a.push_back({4'd2, 8'h33}); exp_wr_a.push_back({4'd3, 8'h44});
      start_a_load();
      host_a(8'h11, 1, 0); host_a(8'h22, 1, 0); host_a(8'h33, 1, 0); host_a(8'h44, 1, 0);
      check_byte_a();
      wait_idle_a();
      check("t1 done/busy/error", 32'({done_a, busy_a, error_a}), 32'b100);
      check("t1 mem_di holds last word", 32'(mem_di_a), 32'h44);

      // Little-endian 16-bit packing.
      exp_wr_b.push_back({4'd0, 16'h1234}); exp_wr_b.push_back({4'd1, 16'h5678});
      @(negedge clk); start_b = 1'b1; @(negedge clk); start_b = 1'b0; sum_b = 8'h00;
      host_b(8'h34); host_b(8'h12); host_b(8'h78); host_b(8'h56);
`ifdef UART_LOADER_CHECKSUM_EN
      host_b(8'h00 - sum_b);
`endif
      repeat (10) @(negedge clk);
      check("t2 done/busy/error b", 32'({done_b, busy_b, error_b}), 32'b100);

      // No reply at all: three requests, all 00, then ERROR with no write.
      start_a_load();
      host_a(8'h00, 0, 0); host_a(8'h00, 0, 0); host_a(8'h00, 0, 0);
      wait_idle_a();
      check("t3 done/busy/error", 32'({done_a, busy_a, error_a}), 32'b001);

      // Replies come late on bytes 0 and 1. The retry count must clear between bytes.
      exp_wr_a.push_back({4'd0, 8'h55}); exp_wr_a.push_back({4'd1, 8'h66});
      exp_wr_a.push_back({4'd2, 8'h77}); exp_wr_a.push_back({4'd3, 8'h88});
      start_a_load();
      host_a(8'h00, 0, 0); host_a(8'h00, 0, 0); host_a(8'h55, 1, 0);
      host_a(8'h00, 0, 0); host_a(8'h00, 0, 0); host_a(8'h66, 1, 0);
      host_a(8'h77, 1, 0); host_a(8'h88, 1, 0);
      check_byte_a();
      wait_idle_a();
      check("t4 done/busy/error", 32'({done_a, busy_a, error_a}), 32'b100);

      // A reply that coincides with tx_wr is dropped, so the byte times out and is re-requested.
      exp_wr_a.push_back({4'd0, 8'h10}); exp_wr_a.push_back({4'd1, 8'h20});
      exp_wr_a.push_back({4'd2, 8'h30}); exp_wr_a.push_back({4'd3, 8'h40});
      start_a_load();
      host_a(8'h00, 0, 1);
      host_a(8'h10, 1, 0); host_a(8'h20, 1, 0); host_a(8'h30, 1, 0); host_a(8'h40, 1, 0);
      check_byte_a();
      wait_idle_a();
      check("t5 done/busy/error", 32'({done_a, busy_a, error_a}), 32'b100);

      // Reset after two words: outputs clear at once, and a new start begins again at address 0.
      exp_wr_a.push_back({4'd0, 8'hA1}); exp_wr_a.push_back({4'd1, 8'hA2});
      start_a_load();
      host_a(8'hA1, 1, 0); host_a(8'hA2, 1, 0);
      exp_tx_a.push_back(last_tx_a);
      wait_tx_a(ok);
      #2 rst_n = 1'b0;
      #1;
      check("t6 outputs in reset", 32'({tx_wr_a, mem_we_a, busy_a, done_a, error_a, tx_data_a, mem_addr_a, mem_di_a}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_wr_a.push_back({4'd0, 8'hB1}); exp_wr_a.push_back({4'd1, 8'hB2});
      exp_wr_a.push_back({4'd2, 8'hB3}); exp_wr_a.push_back({4'd3, 8'hB4});
      start_a_load();
      host_a(8'hB1, 1, 0); host_a(8'hB2, 1, 0); host_a(8'hB3, 1, 0); host_a(8'hB4, 1, 0);
      check_byte_a();
      wait_idle_a();
      check("t6 restart done/busy/error", 32'({done_a, busy_a, error_a}), 32'b100);

`ifdef UART_LOADER_CHECKSUM_EN
      // Data bytes 01,02,03,04 sum to 0A. The good check byte is F6, so F7 must fail.
      exp_wr_a.push_back({4'd0, 8'h01}); exp_wr_a.push_back({4'd1, 8'h02});
      exp_wr_a.push_back({4'd2, 8'h03}); exp_wr_a.push_back({4'd3, 8'h04});
      start_a_load();
      host_a(8'h01, 1, 0); host_a(8'h02, 1, 0); host_a(8'h03, 1, 0); host_a(8'h04, 1, 0);
      host_a(8'hF6, 1, 0);
      wait_idle_a();
      check("t7 good checksum", 32'({done_a, busy_a, error_a}), 32'b100);
      exp_wr_a.push_back({4'd0, 8'h01}); exp_wr_a.push_back({4'd1, 8'h02});
      exp_wr_a.push_back({4'd2, 8'h03}); exp_wr_a.push_back({4'd3, 8'h04});
      start_a_load();
      host_a(8'h01, 1, 0); host_a(8'h02, 1, 0); host_a(8'h03, 1, 0); host_a(8'h04, 1, 0);
      host_a(8'hF7, 1, 0);
      wait_idle_a();
      check("t7 bad checksum", 32'({done_a, busy_a, error_a}), 32'b001);
`endif

      repeat (5) @(negedge clk);
      check("leftover expected writes a", 32'(exp_wr_a.size()), 32'd0);
      check("leftover expected requests a", 32'(exp_tx_a.size()), 32'd0);
      check("leftover expected writes b", 32'(exp_wr_b.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Backstop against a hung run.
   initial begin
      #2000000;
      $display("FAIL global time limit");
      $fatal(1, "time limit");
   end

endmodule
